vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 115 +++++++++++
 tb/tb_vga_timing_gen.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: divides the board clock down to the pixel rate and
// produces scan position, registered sync/blank decode and line/frame pulses.
module vga_timing_gen #(
   parameter int DIV         = 4,
   parameter int H_TOTAL     = 800,
   parameter int H_SYNC      = 96,
   parameter int H_ACT_START = 144,
   parameter int H_ACT_END   = 784,
   parameter int V_TOTAL     = 525,
   parameter int V_SYNC      = 2,
   parameter int V_ACT_START = 35,
   parameter int V_ACT_END   = 515
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pix_en,
   output logic [9:0] hCount,
   output logic [9:0] vCount,
   output logic       hSync,
   output logic       vSync,
   output logic       bright,
   output logic       line_start,
   output logic       frame_start
);

   localparam int            DW       = $clog2(DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]    H_SYNC_C = 10'(H_SYNC);
   localparam logic [9:0]    V_SYNC_C = 10'(V_SYNC);
   localparam logic [9:0]    H_AS     = 10'(H_ACT_START);
   localparam logic [9:0]    H_AE     = 10'(H_ACT_END);
   localparam logic [9:0]    V_AS     = 10'(V_ACT_START);
   localparam logic [9:0]    V_AE     = 10'(V_ACT_END);

   logic [DW-1:0] r_div;
   logic [9:0]    r_h;
   logic [9:0]    r_v;
   logic          r_hsync;
   logic          r_vsync;
   logic          r_bright;
   logic          r_line_start;
   logic          r_frame_start;

   logic [DW-1:0] w_div_next;
   logic [9:0]    w_h_next;
   logic [9:0]    w_v_next;
   logic          w_div_last;
   logic          w_h_wrap;
   logic          w_frame_wrap;

   // Next-state counters; decode below uses these so outputs track the new position.
   always_comb begin
      w_div_last   = (r_div == DIV_LAST);
      w_h_wrap     = w_div_last && (r_h == H_LAST);
      w_frame_wrap = w_h_wrap && (r_v == V_LAST);

      if (w_div_last) begin
         w_div_next = {DW{1'b0}};
      end else begin
         w_div_next = r_div + DW'(1);
      end

      if (!w_div_last) begin
         w_h_next = r_h;
      end else if (w_h_wrap) begin
         w_h_next = 10'd0;
      end else begin
         w_h_next = r_h + 10'd1;
      end

      if (!w_h_wrap) begin
         w_v_next = r_v;
      end else if (r_v == V_LAST) begin
         w_v_next = 10'd0;
      end else begin
         w_v_next = r_v + 10'd1;
      end
   end

   // Counter, decode and pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div         <= {DW{1'b0}};
         r_h           <= 10'd0;
         r_v           <= 10'd0;
         r_hsync       <= 1'b0;
         r_vsync       <= 1'b0;
         r_bright      <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_div         <= w_div_next;
         r_h           <= w_h_next;
         r_v           <= w_v_next;
         r_hsync       <= !(w_h_next < H_SYNC_C);
         r_vsync       <= !(w_v_next < V_SYNC_C);
         r_bright      <= (w_h_next >= H_AS) && (w_h_next < H_AE) &&
                          (w_v_next >= V_AS) && (w_v_next < V_AE);
         r_line_start  <= w_h_wrap;
         r_frame_start <= w_frame_wrap;
      end
   end

   assign pix_en      = w_div_last;
   assign hCount      = r_h;
   assign vCount      = r_v;
   assign hSync       = r_hsync;
   assign vSync       = r_vsync;
   assign bright      = r_bright;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (20x12 pixels, DIV=4) so that
// several whole frames fit in a short run.
module tb_vga_timing_gen;

   localparam int DIV = 4;
   localparam int HT  = 20;
   localparam int HS  = 3;
   localparam int HAS = 5;
   localparam int HAE = 17;
   localparam int VT  = 12;
   localparam int VS  = 2;
   localparam int VAS = 3;
   localparam int VAE = 10;
   localparam int LINE_CLK  = DIV * HT;
   localparam int FRAME_CLK = DIV * HT * VT;

   logic       clk;
   logic       rst;
   logic       pix_en;
   logic [9:0] hCount;
   logic [9:0] vCount;
   logic       hSync;
   logic       vSync;
   logic       bright;
   logic       line_start;
   logic       frame_start;

   int n_cmp;
   int n_err;
   int cyc;

   vga_timing_gen #(
      .DIV(DIV), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT_END(HAE),
      .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT_END(VAE)
   ) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .hCount(hCount), .vCount(vCount),
      .hSync(hSync), .vSync(vSync), .bright(bright),
      .line_start(line_start), .frame_start(frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, " hCount"}, int'(hCount), 0);
      check_val({tag, " vCount"}, int'(vCount), 0);
      check_val({tag, " hSync"}, int'(hSync), 0);
      check_val({tag, " vSync"}, int'(vSync), 0);
      check_val({tag, " bright"}, int'(bright), 0);
      check_val({tag, " pix_en"}, int'(pix_en), 0);
      check_val({tag, " line_start"}, int'(line_start), 0);
      check_val({tag, " frame_start"}, int'(frame_start), 0);
   endtask

   // Reference derived purely from the clock count since reset release.
   task automatic check_model(input int t);
      int d, p, h, v;
      d = t % DIV;
      p = t / DIV;
      h = p % HT;
      v = (p / HT) % VT;
      check_val("pix_en", int'(pix_en), int'(d == DIV - 1));
      check_val("hCount", int'(hCount), h);
      check_val("vCount", int'(vCount), v);
      check_val("hSync", int'(hSync), int'(!(h < HS)));
      check_val("vSync", int'(vSync), int'(!(v < VS)));
      check_val("bright", int'(bright),
                int'((h >= HAS) && (h < HAE) && (v >= VAS) && (v < VAE)));
      check_val("line_start", int'(line_start), int'((t > 0) && (t % LINE_CLK == 0)));
      check_val("frame_start", int'(frame_start), int'((t > 0) && (t % FRAME_CLK == 0)));
   endtask

   // Hand-computed spot values at chosen cycles after release.
   task automatic check_directed(input int t);
      case (t)
         3:   check_val("first pix_en", int'(pix_en), 1);
         4:   check_val("h after 1st pix", int'(hCount), 1);
         7:   check_val("h stable 4clk", int'(hCount), 1);
         8:   check_val("h after 2nd pix", int'(hCount), 2);
         11:  check_val("hSync h=2", int'(hSync), 0);
         12:  check_val("hSync h=3", int'(hSync), 1);
         79:  check_val("h before wrap", int'(hCount), 19);
         80:  check_val("line wrap v", int'(vCount), 1);
         81:  check_val("line_start 1clk", int'(line_start), 0);
         120: check_val("vSync v=1", int'(vSync), 0);
         160: check_val("vSync v=2", int'(vSync), 1);
         180: check_val("bright (5,2)", int'(bright), 0);
         256: check_val("bright (4,3)", int'(bright), 0);
         260: check_val("bright (5,3)", int'(bright), 1);
         304: check_val("bright (16,3)", int'(bright), 1);
         308: check_val("bright (17,3)", int'(bright), 0);
         740: check_val("bright (5,9)", int'(bright), 1);
         784: check_val("bright (16,9)", int'(bright), 1);
         820: check_val("bright (5,10)", int'(bright), 0);
         959: check_val("v before fwrap", int'(vCount), 11);
         960: check_val("frame wrap v", int'(vCount), 0);
         961: check_val("frame_start 1clk", int'(frame_start), 0);
         default: ;
      endcase
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      cyc   = 0;
      rst   = 1'b0;
      repeat (10) @(negedge clk);
      check_reset_state("rst hold");

      rst = 1'b1;
      #1;
      for (int t = 0; t <= 3 * FRAME_CLK + 440 + 1; t++) begin
         cyc = t;
         check_model(t);
         check_directed(t);
         @(negedge clk);
      end

      rst = 1'b0;
      #1;
      check_reset_state("rst async");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_reset_state("rst mid");
      end

      rst = 1'b1;
      #1;
      for (int t = 0; t <= FRAME_CLK + 2; t++) begin
         cyc = t;
         check_model(t);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
